// File: rtl/traffic_phase_timer.sv
// Per-phase countdown timer feeding the traffic controller's timer_done input.
// Reloads on every legal light change and counts prescaled ticks down to a one-cycle done pulse.
module traffic_phase_timer #(
    parameter int CLK_DIV         = 4,
    parameter int GREEN_TICKS     = 5,
    parameter int YELLOW_TICKS    = 2,
    parameter int ALLRED_TICKS    = 1,
    parameter int MIN_GREEN_TICKS = 2,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [2:0]       ns_light,
    input  logic [2:0]       ew_light,
    input  logic             ped_request,
    output logic             timer_done,
    output logic [CNT_W-1:0] remaining,
    output logic             phase_err
);

    localparam logic [2:0] GRN = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] RED = 3'b001;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        PH_ALLRED,
        PH_GREEN,
        PH_YELLOW,
        PH_ILLEGAL
    } phase_t;

    phase_t           phase;
    logic [5:0]       lights_q;
    logic [PW-1:0]    prescaler;
    logic [CNT_W-1:0] duration;
    logic             tick;
    logic             changed;
    logic             truncate;

    always_comb begin
        phase = PH_ILLEGAL;
        if (ns_light == RED && ew_light == RED) begin
            phase = PH_ALLRED;
        end else if ((ns_light == GRN && ew_light == RED) ||
                     (ns_light == RED && ew_light == GRN)) begin
            phase = PH_GREEN;
        end else if ((ns_light == YEL && ew_light == RED) ||
                     (ns_light == RED && ew_light == YEL)) begin
            phase = PH_YELLOW;
        end
    end

    always_comb begin
        duration = CNT_W'(ALLRED_TICKS);
        case (phase)
            PH_GREEN:  duration = CNT_W'(GREEN_TICKS);
            PH_YELLOW: duration = CNT_W'(YELLOW_TICKS);
            default:   duration = CNT_W'(ALLRED_TICKS);
        endcase
    end

    assign tick     = enable && (prescaler == PW'(CLK_DIV - 1));
    assign changed  = ({ns_light, ew_light} != lights_q);
    // A disabled timer keeps remaining frozen, so truncation also waits for enable.
    assign truncate = enable && (phase == PH_GREEN) && ped_request &&
                      (remaining > CNT_W'(MIN_GREEN_TICKS));

    always_ff @(posedge clk) begin
        if (rst) begin
            lights_q   <= {RED, RED};
            remaining  <= CNT_W'(ALLRED_TICKS);
            prescaler  <= '0;
            timer_done <= 1'b0;
            phase_err  <= 1'b0;
        end else if (phase == PH_ILLEGAL) begin
            // lights_q left stale so the return to a legal phase reloads.
            phase_err  <= 1'b1;
            timer_done <= 1'b0;
        end else if (changed) begin
            remaining  <= duration;
            prescaler  <= '0;
            lights_q   <= {ns_light, ew_light};
            timer_done <= 1'b0;
            phase_err  <= 1'b0;
        end else begin
            phase_err <= 1'b0;
            if (enable) begin
                prescaler <= tick ? '0 : prescaler + PW'(1);
            end
            if (truncate) begin
                remaining  <= CNT_W'(MIN_GREEN_TICKS);
                timer_done <= 1'b0;
            end else if (tick && remaining != '0) begin
                remaining  <= remaining - CNT_W'(1);
                timer_done <= (remaining == CNT_W'(1));
            end else begin
                timer_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer: the driver pushes the edge number at which
// each timer_done pulse must appear; a monitor pops and checks whenever timer_done is seen.
module tb_traffic_phase_timer;

    localparam int CNT_W = 8;
    localparam logic [2:0] GRN = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] RED = 3'b001;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [2:0]       ns_light;
    logic [2:0]       ew_light;
    logic             ped_request;
    logic             timer_done;
    logic [CNT_W-1:0] remaining;
    logic             phase_err;

    logic [31:0] exp_q[$];
    logic [31:0] cyc;
    int          n_cmp;
    int          n_bad;

    traffic_phase_timer #(
        .CLK_DIV(4), .GREEN_TICKS(5), .YELLOW_TICKS(2), .ALLRED_TICKS(1),
        .MIN_GREEN_TICKS(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .ns_light(ns_light),
        .ew_light(ew_light), .ped_request(ped_request), .timer_done(timer_done),
        .remaining(remaining), .phase_err(phase_err)
    );

    // clock / edge counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = '0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_lights(input logic [2:0] ns, input logic [2:0] ew);
        ns_light = ns;
        ew_light = ew;
    endtask

    // monitor
    always @(negedge clk) begin
        if (!rst && timer_done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done at edge %0d: got pulse, expected none", cyc);
            end else begin
                check("done_edge", cyc, exp_q.pop_front());
                check("done_remaining", 32'(remaining), 32'd0);
            end
        end
    end

    // driver
    initial begin
        logic [31:0] r;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        enable = 1'b1;
        ped_request = 1'b0;
        set_lights(RED, RED);
        step(3);
        check("rst_remaining", 32'(remaining), 32'd1);
        check("rst_done", 32'(timer_done), 32'd0);
        check("rst_err", 32'(phase_err), 32'd0);

        // 1: all-red after reset, tick on 4th enabled edge
        rst = 1'b0;
        exp_q.push_back(cyc + 32'd4);
        step(4);
        check("allred_remaining", 32'(remaining), 32'd0);
        step(6);
        check("allred_hold", 32'(remaining), 32'd0);

        // 2: green 5 ticks, yellow 2, all-red 1
        set_lights(GRN, RED);
        r = cyc + 32'd1;
        exp_q.push_back(r + 32'd20);
        step(1);
        check("green_reload", 32'(remaining), 32'd5);
        step(20);
        check("green_end", 32'(remaining), 32'd0);
        set_lights(YEL, RED);
        r = cyc + 32'd1;
        exp_q.push_back(r + 32'd8);
        step(1);
        check("yellow_reload", 32'(remaining), 32'd2);
        step(8);
        set_lights(RED, RED);
        r = cyc + 32'd1;
        exp_q.push_back(r + 32'd4);
        step(1);
        check("allred_reload", 32'(remaining), 32'd1);
        step(4);

        // 3: pedestrian truncation at remaining=4, then ignored at remaining=2
        set_lights(GRN, RED);
        r = cyc + 32'd1;
        step(5);
        check("ped_before", 32'(remaining), 32'd4);
        ped_request = 1'b1;
        exp_q.push_back(r + 32'd12);
        step(1);
        check("ped_truncate", 32'(remaining), 32'd2);
        step(1);
        check("ped_no_change", 32'(remaining), 32'd2);
        ped_request = 1'b0;
        step(6);
        check("ped_end", 32'(remaining), 32'd0);

        // 4: enable low for 10 edges mid-green delays done by 10
        set_lights(RED, GRN);
        r = cyc + 32'd1;
        step(7);
        check("en_before", 32'(remaining), 32'd4);
        enable = 1'b0;
        exp_q.push_back(r + 32'd30);
        step(10);
        check("en_frozen", 32'(remaining), 32'd4);
        enable = 1'b1;
        step(14);
        check("en_end", 32'(remaining), 32'd0);

        // 5: illegal green/green holds the count, legal restore reloads
        set_lights(RED, YEL);
        step(1);
        check("ill_yellow", 32'(remaining), 32'd2);
        set_lights(GRN, GRN);
        step(1);
        check("ill_err1", 32'(phase_err), 32'd1);
        check("ill_hold1", 32'(remaining), 32'd2);
        step(2);
        check("ill_err3", 32'(phase_err), 32'd1);
        check("ill_hold3", 32'(remaining), 32'd2);
        set_lights(RED, GRN);
        step(1);
        check("ill_clear", 32'(phase_err), 32'd0);
        check("ill_reload", 32'(remaining), 32'd5);

        // 6: reset mid-green with prescaler at 1
        step(9);
        check("rst_mid_before", 32'(remaining), 32'd3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_mid_remaining", 32'(remaining), 32'd1);
        check("rst_mid_done", 32'(timer_done), 32'd0);
        check("rst_mid_err", 32'(phase_err), 32'd0);
        set_lights(RED, RED);
        exp_q.push_back(cyc + 32'd4);
        step(4);
        check("rst_mid_end", 32'(remaining), 32'd0);
        step(5);

        @(negedge clk);
        check("pending_pulses", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
